// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered execute stage of the URCPU datapath.
// Accepts an operand pair and opcode over valid/ready and registers result,
// zero and carry for writeback. XOR/AND/OR/ADD/SUB/PASS complete in one
// cycle. Shifts by 2..19 bits iterate one bit per cycle in a working
// register. The result register only ever holds completed results.
// Optional feature: define ALU_EXEC_STAGE_OVF_EN to add a registered signed
// overflow flag (ovf) for ADD/SUB.

// Combinational XOR primitive shared with the rest of the ALU.
module xor_gate #(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = a_i ^ b_i;
endmodule

module alu_exec_stage #(
  parameter int WIDTH   = 20,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry
`ifdef ALU_EXEC_STAGE_OVF_EN
  ,
  output logic             ovf
`endif
);

  typedef enum logic [2:0] {
    OP_XOR  = 3'b000,
    OP_AND  = 3'b001,
    OP_OR   = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_SHL  = 3'b101,
    OP_SHR  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_e;

  localparam logic [SHAMT_W-1:0] AMT_ONE   = SHAMT_W'(1);
  localparam logic [SHAMT_W-1:0] AMT_WIDTH = SHAMT_W'(WIDTH);

  // One-bit shift step: returns {bit shifted out, shifted word}.
  function automatic logic [WIDTH:0] shift1(input logic [WIDTH-1:0] w,
                                            input logic right);
    if (right) shift1 = {w[0], 1'b0, w[WIDTH-1:1]};
    else       shift1 = {w[WIDTH-1], w[WIDTH-2:0], 1'b0};
  endfunction

  // Registered state
  state_e             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               dir_q, dir_d;   // 1: shift right

  // Combinational ALU primitives
  logic [WIDTH-1:0]   xor_y;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     dif_ext;
  logic [SHAMT_W-1:0] amt;
  logic               is_shr;
  logic [WIDTH:0]     first_step;
  logic [WIDTH:0]     iter_step;
  logic               accept;

  // Load bundle: a completed result written into the output registers.
  logic               load;
  logic [WIDTH-1:0]   load_res;
  logic               load_c;

`ifdef ALU_EXEC_STAGE_OVF_EN
  logic ovf_q, ovf_d, load_v;
  logic add_ovf, sub_ovf;
  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif_ext[WIDTH-1] != a[WIDTH-1]);
  assign ovf     = ovf_q;
`endif

  xor_gate #(.WIDTH(WIDTH)) u_xor (
    .a_i (a),
    .b_i (b),
    .y_o (xor_y)
  );

  assign sum_ext    = {1'b0, a} + {1'b0, b};
  // Subtract as a + ~b + 1; the inverted carry-out is the borrow.
  assign dif_ext    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign amt        = b[SHAMT_W-1:0];
  assign is_shr     = (op == OP_SHR);
  assign first_step = shift1(a, is_shr);
  assign iter_step  = shift1(work_q, dir_q);

  // Combinational from out_ready so a draining output can be refilled on the same edge.
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;

  // Next-state and datapath: accept/issue in IDLE, iterate shifts in SHIFT.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    out_valid_d = out_valid_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    dir_d       = dir_q;
    load        = 1'b0;
    load_res    = '0;
    load_c      = 1'b0;
`ifdef ALU_EXEC_STAGE_OVF_EN
    load_v      = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept) begin
          case (op_e'(op))
            OP_XOR: begin load = 1'b1; load_res = xor_y; end
            OP_AND: begin load = 1'b1; load_res = a & b; end
            OP_OR:  begin load = 1'b1; load_res = a | b; end
            OP_ADD: begin
              load     = 1'b1;
              load_res = sum_ext[WIDTH-1:0];
              load_c   = sum_ext[WIDTH];
`ifdef ALU_EXEC_STAGE_OVF_EN
              load_v   = add_ovf;
`endif
            end
            OP_SUB: begin
              load     = 1'b1;
              load_res = dif_ext[WIDTH-1:0];
              load_c   = ~dif_ext[WIDTH];
`ifdef ALU_EXEC_STAGE_OVF_EN
              load_v   = sub_ovf;
`endif
            end
            OP_SHL, OP_SHR: begin
              if (amt == '0) begin
                load     = 1'b1;
                load_res = a;
              end else if (amt >= AMT_WIDTH) begin
                // Everything shifted out; only a shift of exactly WIDTH leaves a last bit.
                load     = 1'b1;
                load_res = '0;
                load_c   = (amt == AMT_WIDTH) ? (is_shr ? a[WIDTH-1] : a[0]) : 1'b0;
              end else if (amt == AMT_ONE) begin
                load     = 1'b1;
                load_res = first_step[WIDTH-1:0];
                load_c   = first_step[WIDTH];
              end else begin
                // The accept edge performs the first shift; amt-1 steps remain.
                work_d      = first_step[WIDTH-1:0];
                cnt_d       = amt - AMT_ONE;
                dir_d       = is_shr;
                state_d     = S_SHIFT;
                out_valid_d = 1'b0;
              end
            end
            default: begin load = 1'b1; load_res = a; end
          endcase
          if (load) out_valid_d = 1'b1;
        end
      end
      S_SHIFT: begin
        work_d = iter_step[WIDTH-1:0];
        cnt_d  = cnt_q - AMT_ONE;
        if (cnt_q == AMT_ONE) begin
          load        = 1'b1;
          load_res    = iter_step[WIDTH-1:0];
          load_c      = iter_step[WIDTH];
          out_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    result_d = load ? load_res : result_q;
    zero_d   = load ? (load_res == '0) : zero_q;
    carry_d  = load ? load_c : carry_q;
`ifdef ALU_EXEC_STAGE_OVF_EN
    ovf_d    = load ? load_v : ovf_q;
`endif
  end

  // State, output and working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    if (!rst_n) begin
      // NOTE: the working register and counter are reset too, so an aborted shift leaves no trace.
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      work_q      <= '0;
      cnt_q       <= '0;
      dir_q       <= 1'b0;
`ifdef ALU_EXEC_STAGE_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      dir_q       <= dir_d;
`ifdef ALU_EXEC_STAGE_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Testbench for alu_exec_stage: transaction-level reference model plus a
// per-cycle compare process, directed literal checks and random stimulus.
module tb_alu_exec_stage;

  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
`ifdef ALU_EXEC_STAGE_OVF_EN
  logic         ovf;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  alu_exec_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry)
`ifdef ALU_EXEC_STAGE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    int           lat;
  } ref_t;

  // What an op must produce, from plain arithmetic on the operand values.
  function automatic ref_t ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    ref_t   r;
    longint ux, uy, sx, sy, s, sh;
    int     n;
    ux = longint'(x);
    uy = longint'(y);
    sx = x[W-1] ? ux - (longint'(1) << W) : ux;
    sy = y[W-1] ? uy - (longint'(1) << W) : uy;
    n  = int'(y[4:0]);
    r.res = '0; r.c = 1'b0; r.v = 1'b0; r.lat = 1;
    case (o)
      3'd0: r.res = x ^ y;
      3'd1: r.res = x & y;
      3'd2: r.res = x | y;
      3'd3: begin
        s     = ux + uy;
        r.res = s[W-1:0];
        r.c   = s[W];
        r.v   = ((sx + sy) > 524287) || ((sx + sy) < -524288);
      end
      3'd4: begin
        s     = ux - uy;
        r.res = s[W-1:0];
        r.c   = (ux < uy);
        r.v   = ((sx - sy) > 524287) || ((sx - sy) < -524288);
      end
      3'd5: begin
        sh    = ux << n;
        r.res = sh[W-1:0];
        r.c   = (n >= 1 && n <= W) ? x[W-n] : 1'b0;
        r.lat = (n >= 2 && n < W) ? n : 1;
      end
      3'd6: begin
        sh    = ux >> n;
        r.res = sh[W-1:0];
        r.c   = (n >= 1 && n <= W) ? x[n-1] : 1'b0;
        r.lat = (n >= 2 && n < W) ? n : 1;
      end
      default: r.res = x;
    endcase
    return r;
  endfunction

  logic         m_valid = 1'b0;
  logic [W-1:0] m_res = '0;
  logic         m_c = 1'b0;
  logic         m_z = 1'b0;
  logic         m_v = 1'b0;
  int           m_busy = 0;   // edges left before a pending shift completes
  ref_t         pend;
  ref_t         cur;
  logic         m_ready;

  always_comb cur = ref_op(op, a, b);
  assign m_ready = (m_busy == 0) && (!m_valid || out_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_res   <= '0;
      m_c     <= 1'b0;
      m_z     <= 1'b0;
      m_v     <= 1'b0;
      m_busy  <= 0;
    end else if (m_busy != 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_valid <= 1'b1;
        m_res   <= pend.res;
        m_c     <= pend.c;
        m_v     <= pend.v;
        m_z     <= (pend.res == '0);
      end
    end else if (in_valid && m_ready) begin
      if (cur.lat == 1) begin
        m_valid <= 1'b1;
        m_res   <= cur.res;
        m_c     <= cur.c;
        m_v     <= cur.v;
        m_z     <= (cur.res == '0);
      end else begin
        m_valid <= 1'b0;
        m_busy  <= cur.lat - 1;
        pend    <= cur;
      end
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    check_bit("in_ready", in_ready, m_ready);
    check_bit("out_valid", out_valid, m_valid);
    if (m_valid || !rst_n) begin
      check("result", result, m_res);
      check_bit("zero", zero, m_z);
      check_bit("carry", carry, m_c);
`ifdef ALU_EXEC_STAGE_OVF_EN
      check_bit("ovf", ovf, m_v);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for acceptance and for its result; lat counts edges from accept.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
    int guard;
    guard = 0;
    op = o; a = x; b = y; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check_bit("accept_wait", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    op = 3'($urandom);
    a  = W'($urandom);
    b  = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 50) begin
      check_bit("busy_in_ready", in_ready, 1'b0);
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int xfers;
    int ops[6] = '{0, 1, 2, 3, 4, 7};

    // Reset
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("rst_result", result, 20'h00000);
    check_bit("rst_zero", zero, 1'b0);
    check_bit("rst_carry", carry, 1'b0);
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // XOR
    do_op(3'b000, 20'hAAAAA, 20'h55555, lat);
    check_int("xor_lat", lat, 1);
    check("xor_res", result, 20'hFFFFF);
    check_bit("xor_zero", zero, 1'b0);
    check_bit("xor_carry", carry, 1'b0);

    // ADD wrap
    do_op(3'b011, 20'hFFFFF, 20'h00001, lat);
    check("add_res", result, 20'h00000);
    check_bit("add_zero", zero, 1'b1);
    check_bit("add_carry", carry, 1'b1);

    // SUB borrow
    do_op(3'b100, 20'h00003, 20'h00005, lat);
    check("sub_res", result, 20'hFFFFE);
    check_bit("sub_borrow", carry, 1'b1);

`ifdef ALU_EXEC_STAGE_OVF_EN
    do_op(3'b011, 20'h7FFFF, 20'h00001, lat);
    check("ovf_res", result, 20'h80000);
    check_bit("ovf_flag", ovf, 1'b1);
`endif

    // Iterative shift
    do_op(3'b101, 20'h80001, 20'h00004, lat);
    check_int("shl4_lat", lat, 4);
    check("shl4_res", result, 20'h00010);
    check_bit("shl4_carry", carry, 1'b0);

    do_op(3'b110, 20'h00003, 20'h00001, lat);
    check_int("shr1_lat", lat, 1);
    check("shr1_res", result, 20'h00001);
    check_bit("shr1_carry", carry, 1'b1);

    do_op(3'b101, 20'h12345, 20'h00019, lat);
    check_int("shl25_lat", lat, 1);
    check("shl25_res", result, 20'h00000);

    // Backpressure
    tick();
    out_ready = 1'b0;
    do_op(3'b001, 20'hF0F0F, 20'h0FFFF, lat);
    check("bp_res", result, 20'h00F0F);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_res", result, 20'h00F0F);
      check_bit("bp_hold_valid", out_valid, 1'b1);
      check_bit("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    xfers = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid && out_ready) xfers++;
      tick();
    end
    check_int("bp_transfers", xfers, 1);

    // Throughput: back-to-back single-cycle ops
    for (int i = 0; i < 10; i++) begin
      op = 3'(ops[$urandom_range(5)]);
      a  = W'($urandom);
      b  = W'($urandom);
      in_valid = 1'b1;
      check_bit("tp_in_ready", in_ready, 1'b1);
      tick();
      check_bit("tp_out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    tick();

    // Random mix with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(1) == 1);
      op        = 3'($urandom);
      a         = W'($urandom);
      b         = W'($urandom);
      out_ready = ($urandom_range(3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (25) tick();

    // Reset in the middle of a shift
    op = 3'b110; a = 20'hABCDE; b = 20'h0000F; in_valid = 1'b1;
    check_bit("mid_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check_bit("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_result", result, 20'h00000);
    check_bit("mid_rst_zero", zero, 1'b0);
    check_bit("mid_rst_carry", carry, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_bit("abort_no_valid", out_valid, 1'b0);
    end
    do_op(3'b111, 20'h12345, 20'h00000, lat);
    check_int("pass_lat", lat, 1);
    check("pass_res", result, 20'h12345);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
